// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants and fetch buffer entry types
package riscv_pkg;

  // canonical RISC-V nop: addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // width of pending/drop counters; BUF_DEPTH never exceeds 4
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    READY   = 2'd2
  } entry_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular instruction buffer with head/tail pointers
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc,
  input  logic [31:0]      alloc_pc,
  input  logic             resp,
  input  logic [31:0]      resp_data,
  input  logic             free,
  output logic             slot_avail,
  output logic             head_ready,
  output logic [31:0]      head_pc,
  output logic [31:0]      head_instr,
  output logic [CNT_W-1:0] pending_cnt
);

  localparam int PW = $clog2(BUF_DEPTH);

  entry_state_t   state_q [BUF_DEPTH];
  logic [31:0]    pc_q    [BUF_DEPTH];
  logic [31:0]    instr_q [BUF_DEPTH];
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [PW-1:0]  resp_idx;
  logic [PW-1:0]  cand;
  logic           resp_hit;
  int             scan_idx;

  // pointers wrap at BUF_DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_ready = (state_q[head_q] == READY);
  assign head_pc    = pc_q[head_q];
  assign head_instr = instr_q[head_q];

  // the tail slot is usable if empty, or if it is the head being retired this cycle
  assign slot_avail = (state_q[tail_q] == EMPTY) || (free && (tail_q == head_q));

  // count pending entries and locate the oldest one, scanning from the head
  always_comb begin
    pending_cnt = '0;
    resp_hit    = 1'b0;
    resp_idx    = head_q;
    cand        = head_q;
    scan_idx    = 0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (state_q[i] == PENDING) pending_cnt = pending_cnt + 1'b1;
    end
    for (int i = BUF_DEPTH - 1; i >= 0; i--) begin
      scan_idx = int'(head_q) + i;
      if (scan_idx >= BUF_DEPTH) scan_idx = scan_idx - BUF_DEPTH;
      cand = PW'(scan_idx);
      if (state_q[cand] == PENDING) begin
        resp_hit = 1'b1;
        resp_idx = cand;
      end
    end
  end

  // entry state and pointer updates; flush empties everything and rewinds both pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        state_q[i] <= EMPTY;
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        state_q[i] <= EMPTY;
      end
    end else begin
      if (free) begin
        state_q[head_q] <= EMPTY;
        head_q          <= ptr_inc(head_q);
      end
      if (resp && resp_hit) begin
        state_q[resp_idx] <= READY;
        instr_q[resp_idx] <= resp_data;
      end
      if (alloc) begin
        state_q[tail_q] <= PENDING;
        pc_q[tail_q]    <= alloc_pc;
        tail_q          <= ptr_inc(tail_q);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, memory request control, stale-response dropping
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(BUF_DEPTH);

  logic [31:0]      pc_q;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] pending_cnt;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_redirect;
  logic             slot_avail;
  logic             head_ready;
  logic [31:0]      head_pc;
  logic [31:0]      head_instr;
  logic             alloc;
  logic             free;
  logic             resp;

  // memory-side outstanding = live pending entries plus responses still owed to a flushed stream
  assign inflight  = pending_cnt + drop_cnt;
  assign imem_req  = !rst && !redirect_valid && slot_avail && (inflight < DEPTH_L);
  assign imem_addr = pc_q;
  assign alloc     = imem_req && imem_ready;
  assign free      = head_ready && dec_ready && !redirect_valid;
  assign resp      = imem_rvalid && (drop_cnt == '0);

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .alloc       (alloc),
    .alloc_pc    (pc_q),
    .resp        (resp),
    .resp_data   (imem_rdata),
    .free        (free),
    .slot_avail  (slot_avail),
    .head_ready  (head_ready),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .pending_cnt (pending_cnt)
  );

  // on redirect every pending entry becomes a response to drop, less one arriving right now
  always_comb begin
    drop_redirect = drop_cnt + pending_cnt;
    if (imem_rvalid && (drop_redirect != '0)) drop_redirect = drop_redirect - 1'b1;
  end

  // PC and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc_q     <= {redirect_pc[31:2], 2'b00};
      drop_cnt <= drop_redirect;
    end else begin
      if (alloc) pc_q <= pc_q + 32'd4;
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // decode outputs come straight from the head entry; idle shows a nop at pc 0
  always_comb begin
    dec_valid = head_ready;
    dec_instr = NOP;
    dec_pc    = '0;
    if (head_ready) begin
      dec_instr = head_instr;
      dec_pc    = head_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t mem_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  int ready_mode = 1;

  logic        drv_dr = 1'b1;
  logic        drv_rv = 1'b0;
  logic [31:0] drv_rp = '0;
  logic [31:0] ref_pc = RST_PC;

  logic        s_req, s_dv;
  logic [31:0] s_addr, s_dpc, s_dins;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_instr;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h2468_ACE1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    exp_t e;
    rsp_t r;
    @(negedge clk);
    case (ready_mode)
      0:       imem_ready = 1'b0;
      1:       imem_ready = 1'b1;
      default: imem_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    dec_ready      = drv_dr;
    redirect_valid = drv_rv;
    redirect_pc    = drv_rp;
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    s_dv   = dec_valid;
    s_dpc  = dec_pc;
    s_dins = dec_instr;
    if (prev_stall) begin
      chk("hold_valid", 32'(s_dv), 1);
      chk("hold_pc", s_dpc, prev_pc);
      chk("hold_instr", s_dins, prev_instr);
    end
    if (!s_dv) begin
      chk("idle_instr", s_dins, NOP);
      chk("idle_pc", s_dpc, 0);
    end
    if (redirect_valid) chk("req_on_redirect", 32'(s_req), 0);
    else if (s_req) chk("req_addr", s_addr, ref_pc);
    if (s_dv && dec_ready && !redirect_valid) begin
      chk("dec_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dec_pc", s_dpc, e.pc);
        chk("dec_instr", s_dins, e.instr);
      end
    end
    if (!redirect_valid && s_req && imem_ready) begin
      exp_q.push_back('{ref_pc, mem_word(ref_pc)});
      ref_pc = ref_pc + 32'd4;
    end
    if (imem_rvalid) void'(mem_q.pop_front());
    if (s_req && imem_ready) begin
      r.data = mem_word(s_addr);
      r.due  = cyc + $urandom_range(lat_lo, lat_hi);
      mem_q.push_back(r);
    end
    chk("outstanding", 32'(mem_q.size() <= DEPTH), 1);
    if (redirect_valid) begin
      ref_pc = {drv_rp[31:2], 2'b00};
      exp_q.delete();
    end
    prev_stall = s_dv && !dec_ready && !redirect_valid;
    prev_pc    = s_dpc;
    prev_instr = s_dins;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    mem_q.delete();
    exp_q.delete();
    ref_pc = RST_PC;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_dv", 32'(dec_valid), 0);
    chk("rst_instr", dec_instr, NOP);
    chk("rst_pc", dec_pc, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    drv_rv = 1'b1;
    drv_rp = target;
    step();
    drv_rv = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    ready_mode = 0;
    drv_dr = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      done = (mem_q.size() == 0);
    end
    chk("drain_done", 32'(done), 1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (s_req && !redirect_valid && imem_ready) begin
        got = 1;
        chk(tag, s_addr, addr);
      end
    end
    chk({tag, "_seen"}, 32'(got), 1);
  endtask

  task automatic wait_dec(input string tag, input logic [31:0] pc);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (s_dv) begin
        got = 1;
        chk(tag, s_dpc, pc);
      end
    end
    chk({tag, "_seen"}, 32'(got), 1);
  endtask

  initial begin
    do_reset();

    // back-to-back fetch at latency 1
    drv_dr = 1'b1;
    drv_rv = 1'b0;
    ready_mode = 1;
    lat_lo = 1;
    lat_hi = 1;
    step();
    chk("seq_req0", 32'(s_req), 1);
    chk("seq_addr0", s_addr, 32'h0);
    step();
    chk("seq_addr1", s_addr, 32'h4);
    chk("seq_dv1", 32'(s_dv), 0);
    step();
    chk("seq_addr2", s_addr, 32'h8);
    chk("seq_dv2", 32'(s_dv), 1);
    chk("seq_dpc2", s_dpc, 32'h0);
    step();
    chk("seq_dpc3", s_dpc, 32'h4);
    step();
    chk("seq_dpc4", s_dpc, 32'h8);
    repeat (5) step();

    // decode stall: buffer fills, requests stop, outputs hold
    drv_dr = 1'b0;
    repeat (6) step();
    chk("stall_req_off", 32'(s_req), 0);
    chk("stall_dv", 32'(s_dv), 1);
    drv_dr = 1'b1;
    repeat (10) step();

    // redirect to an unaligned target with two requests in flight
    drain();
    redirect_to(32'h200);
    ready_mode = 1;
    lat_lo = 4;
    lat_hi = 4;
    step();
    step();
    chk("redir_pending", 32'(mem_q.size()), 2);
    redirect_to(32'h103);
    #1;
    chk("redir_drop", 32'(dut.drop_cnt), 2);
    lat_lo = 1;
    lat_hi = 1;
    wait_req("redir_addr", 32'h100);
    wait_dec("redir_dpc", 32'h100);

    // redirect colliding with a response and a decode handshake
    drain();
    redirect_to(32'h300);
    ready_mode = 1;
    drv_dr = 1'b0;
    step();
    step();
    drv_dr = 1'b1;
    drv_rv = 1'b1;
    drv_rp = 32'h400;
    step();
    drv_rv = 1'b0;
    chk("coll_dv", 32'(s_dv), 1);
    chk("coll_rvalid", 32'(imem_rvalid), 1);
    #1;
    chk("coll_drop", 32'(dut.drop_cnt), 0);
    wait_dec("coll_dpc", 32'h400);

    // PC wraps past the top of the address space
    redirect_to(32'hFFFF_FFFC);
    wait_req("wrap_top", 32'hFFFF_FFFC);
    wait_req("wrap_zero", 32'h0000_0000);

    // random latency, random backpressure, random redirects
    ready_mode = 2;
    lat_lo = 1;
    lat_hi = 5;
    for (int i = 0; i < 8000; i++) begin
      drv_dr = ($urandom_range(0, 99) < 70);
      drv_rv = ($urandom_range(0, 49) == 0);
      drv_rp = $urandom;
      step();
    end
    drv_rv = 1'b0;
    drv_dr = 1'b1;
    ready_mode = 1;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
